// File: rtl/math_req_arbiter.sv
// ---------------------------------------------------------------------------
// math_req_arbiter
//
// Round-robin arbiter and sequencer that shares one 8-bit math unit between
// NREQ requesters. A request {a, b, op} is accepted from the round-robin
// winner. Its operands are held on the math-unit inputs for ALU_LAT cycles.
// The result is then captured and returned to the winner over a per-requester
// valid/ready response handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready per-requester request handshake (ready is combinational)
//   req_a/b/op      packed per-requester operands (8/8/4 bits each)
//   resp_valid      per-requester result valid
//   resp_ready      per-requester result consume
//   resp_result/dz  shared 16-bit result bus and divide-by-zero flag
//   alu_a/b/op      operands to the shared math unit
//   alu_result      combinational result from the math unit
//   busy            high while a transaction is in flight
//   grant_id        index of the current or last granted requester
//
// State | Meaning
// ------+-------------------------------------------------------------------
// IDLE  | no transaction; grant the round-robin winner of req_valid
// EXEC  | operands held on alu_*; counter runs down to the capture edge
// RESP  | result presented to grant_id until it is consumed
// ---------------------------------------------------------------------------
module math_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    input  logic [4*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [15:0]          resp_result,
    output logic                 resp_dz,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_op,
    input  logic [15:0]          alu_result,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [3:0] OP_DIV = 4'h3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [1:0]         grant_id_q, grant_id_d;
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        result_q, result_d;
    logic               dz_q, dz_d;

    // Requester vectors widened to the full 2-bit index space so that every
    // index select below is a clean 2-bit select regardless of NREQ.
    logic [3:0]         valid_pad;
    logic [3:0]         rready_pad;
    logic [3:0]         win_oh;
    logic [3:0]         gid_oh;

    logic               win_found;
    logic [1:0]         win_idx;
    logic [1:0]         cand_idx;
    int                 cand;
    logic [7:0]         sel_a;
    logic [7:0]         sel_b;
    logic [3:0]         sel_op;
    logic               div_zero;

    assign valid_pad  = 4'(req_valid);
    assign rready_pad = 4'(resp_ready);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 0;
        cand_idx  = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(last_grant_q) + 1 + k) % NREQ;
            cand_idx = cand[1:0];
            if (!win_found && valid_pad[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Operand mux for the winner; constant part-selects only.
    always_comb begin
        sel_a  = 8'h00;
        sel_b  = 8'h00;
        sel_op = 4'h0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == 2'(k)) begin
                sel_a  = req_a[8*k +: 8];
                sel_b  = req_b[8*k +: 8];
                sel_op = req_op[4*k +: 4];
            end
        end
    end

    assign win_oh   = 4'b0001 << win_idx;
    assign gid_oh   = 4'b0001 << grant_id_q;
    assign div_zero = (op_q == OP_DIV) && (b_q == 8'h00);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        dz_d         = dz_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    a_d        = sel_a;
                    b_d        = sel_b;
                    op_d       = sel_op;
                    grant_id_d = win_idx;
                    cnt_d      = CNT_W'(ALU_LAT - 1);
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    // A zero divisor overrides whatever the math unit returns.
                    result_d = div_zero ? 16'hFFFF : alu_result;
                    dz_d     = div_zero;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                // Only the granted requester's ready can close the response.
                if (rready_pad[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 2'(NREQ - 1);
            grant_id_q   <= 2'd0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            op_q         <= 4'h0;
            cnt_q        <= '0;
            result_q     <= 16'h0000;
            dz_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            dz_q         <= dz_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE && win_found) ? win_oh[NREQ-1:0] : '0;
    assign resp_valid  = (state_q == S_RESP) ? gid_oh[NREQ-1:0] : '0;
    assign resp_result = result_q;
    assign resp_dz     = dz_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_math_req_arbiter.sv
module tb_math_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [15:0] req_a, req_b;
    logic [7:0]  req_op;
    logic [15:0] resp_result, alu_result;
    logic        resp_dz, busy;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [1:0]  grant_id;

    logic [1:0]  l3_req_valid, l3_req_ready, l3_resp_valid, l3_resp_ready;
    logic [15:0] l3_req_a, l3_req_b;
    logic [7:0]  l3_req_op;
    logic [15:0] l3_resp_result, l3_alu_result;
    logic        l3_resp_dz, l3_busy;
    logic [7:0]  l3_alu_a, l3_alu_b;
    logic [3:0]  l3_alu_op;
    logic [1:0]  l3_grant_id;

    // Behavioural model of the shared math unit.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        case (op)
            4'h0: return {8'h00, a} + {8'h00, b};
            4'h1: return {8'h00, a} - {8'h00, b};
            4'h2: return {8'h00, a} * {8'h00, b};
            4'h3: return (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
            4'h4: return {8'h00, a & b};
            4'h5: return {8'h00, a | b};
            4'h6: return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] exp_res(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
        if (op == 4'h3 && b == 8'h00) return 16'hFFFF;
        return alu_f(a, b, op);
    endfunction

    assign alu_result    = alu_f(alu_a, alu_b, alu_op);
    assign l3_alu_result = alu_f(l3_alu_a, l3_alu_b, l3_alu_op);

    math_req_arbiter #(.NREQ(2), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_dz(resp_dz),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .grant_id(grant_id)
    );

    math_req_arbiter #(.NREQ(2), .ALU_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(l3_req_valid), .req_ready(l3_req_ready),
        .req_a(l3_req_a), .req_b(l3_req_b), .req_op(l3_req_op),
        .resp_valid(l3_resp_valid), .resp_ready(l3_resp_ready),
        .resp_result(l3_resp_result), .resp_dz(l3_resp_dz),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_op(l3_alu_op), .alu_result(l3_alu_result),
        .busy(l3_busy), .grant_id(l3_grant_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        dz;
    } sb_t;

    sb_t sb_q[$];
    sb_t sb_e;
    int  hs_id_q[$];
    int  hs_cyc_q[$];
    int  hs_cnt = 0;
    int  cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard and handshake log for the ALU_LAT=1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid != 2'b00)
                chk_eq("resp_expected", 32'(sb_q.size() != 0), 32'd1);
            for (int i = 0; i < 2; i++) begin
                if (resp_valid[i] && resp_ready[i] && sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    chk_eq("resp_id", 32'(i), 32'(sb_e.id));
                    chk_eq("resp_result", 32'(resp_result), 32'(sb_e.res));
                    chk_eq("resp_dz", 32'(resp_dz), 32'(sb_e.dz));
                end
            end
            if ((req_valid & req_ready) != 2'b00) begin
                hs_cnt++;
                hs_id_q.push_back(req_ready[1] ? 1 : 0);
                hs_cyc_q.push_back(cyc);
            end
        end
    end

    // Bounded wait, starting and ending 1 time unit after a rising edge.
    task automatic wait_busy(input logic lvl, input string tag);
        for (int i = 0; i < 50; i++) begin
            if (busy == lvl) break;
            @(posedge clk); #1;
        end
        chk_eq(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input logic [15:0] er, input logic ed);
        sb_q.push_back('{id: id, res: er, dz: ed});
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_op[4*id +: 4] = op;
        req_valid[id] = 1'b1;
        wait_busy(1'b1, "op_start");
        req_valid = 2'b00;
        wait_busy(1'b0, "op_done");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [7:0] ra, rb;
    logic [3:0] rop;
    int         rid;
    int         base;

    initial begin
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = '0;
        l3_req_valid = '0; l3_req_a = '0; l3_req_b = '0; l3_req_op = '0; l3_resp_ready = '0;
        @(posedge clk); #1;
        chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
        chk_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk_eq("rst_resp_result", 32'(resp_result), 32'd0);
        chk_eq("rst_resp_dz", 32'(resp_dz), 32'd0);
        chk_eq("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single MUL request from requester 0.
        resp_ready = 2'b11;
        req_a[7:0] = 8'd200; req_b[7:0] = 8'd100; req_op[3:0] = 4'h2;
        req_valid = 2'b01;
        sb_q.push_back('{id: 0, res: 16'h4E20, dz: 1'b0});
        #1;
        chk_eq("single_ready", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk_eq("single_busy", 32'(busy), 32'd1);
        chk_eq("single_alu_a", 32'(alu_a), 32'd200);
        chk_eq("single_exec_novalid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk_eq("single_resp_valid", 32'(resp_valid), 32'b01);
        chk_eq("single_result", 32'(resp_result), 32'h4E20);
        @(posedge clk); #1;
        chk_eq("single_idle", 32'(busy), 32'd0);

        // Fairness: both requesters hold valid continuously.
        pulse_reset();
        hs_id_q.delete(); hs_cyc_q.delete();
        req_a = {8'd5, 8'd1}; req_b = {8'd7, 8'd1}; req_op = {4'h1, 4'h0};
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back('{id: 0, res: 16'h0002, dz: 1'b0});
            sb_q.push_back('{id: 1, res: 16'hFFFE, dz: 1'b0});
        end
        base = hs_cnt;
        req_valid = 2'b11;
        for (int i = 0; i < 100; i++) begin
            if (hs_cnt >= base + 4) break;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        chk_eq("fair_hs_count", 32'(hs_cnt - base), 32'd4);
        wait_busy(1'b0, "fair_done");
        if (hs_id_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk_eq("fair_grant_order", 32'(hs_id_q[k]), 32'(k % 2));
            for (int k = 1; k < 4; k++)
                chk_eq("fair_gap", 32'(hs_cyc_q[k] - hs_cyc_q[k-1]), 32'd3);
        end

        // Divide by zero, then a normal divide.
        run_op(1, 8'd9, 8'd0, 4'h3, 16'hFFFF, 1'b1);
        run_op(1, 8'd9, 8'd2, 4'h3, 16'h0004, 1'b0);

        // Response backpressure on requester 0 while requester 1 waits.
        resp_ready = 2'b00;
        sb_q.push_back('{id: 0, res: 16'h00A5, dz: 1'b0});
        req_a[7:0] = 8'hAA; req_b[7:0] = 8'h0F; req_op[3:0] = 4'h6;
        req_valid = 2'b01;
        wait_busy(1'b1, "bp_start");
        sb_q.push_back('{id: 1, res: 16'h0000, dz: 1'b0});
        req_a[15:8] = 8'd3; req_b[15:8] = 8'd4; req_op[7:4] = 4'h4;
        req_valid = 2'b10;
        resp_ready = 2'b10;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid[0]) break;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            chk_eq("bp_resp_valid", 32'(resp_valid), 32'b01);
            chk_eq("bp_result", 32'(resp_result), 32'h00A5);
            chk_eq("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 2'b11;
        @(posedge clk); #1;
        chk_eq("bp_released_idle", 32'(busy), 32'd0);
        chk_eq("bp_req1_ready", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        chk_eq("bp_req1_granted", 32'(busy), 32'd1);
        chk_eq("bp_grant_id", 32'(grant_id), 32'd1);
        req_valid = 2'b00;
        wait_busy(1'b0, "bp_done");

        // Random operations through the scoreboard.
        for (int n = 0; n < 16; n++) begin
            rid = int'($urandom_range(0, 1));
            ra  = 8'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            rop = 4'($urandom_range(0, 8));
            run_op(rid, ra, rb, rop, exp_res(ra, rb, rop), (rop == 4'h3 && rb == 8'h00));
        end

        // Reset in the middle of EXEC abandons the transaction.
        req_a[7:0] = 8'd3; req_b[7:0] = 8'd4; req_op[3:0] = 4'h0;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk_eq("rmo_in_exec", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("rmo_busy", 32'(busy), 32'd0);
        chk_eq("rmo_resp_valid", 32'(resp_valid), 32'd0);
        chk_eq("rmo_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        req_a = {8'd9, 8'd1}; req_b = {8'd9, 8'd2}; req_op = {4'h1, 4'h0};
        req_valid = 2'b11;
        #1;
        chk_eq("rmo_prio0", 32'(req_ready), 32'b01);
        sb_q.push_back('{id: 0, res: 16'h0003, dz: 1'b0});
        sb_q.push_back('{id: 1, res: 16'h0000, dz: 1'b0});
        wait_busy(1'b1, "rmo_op0_start");
        req_valid = 2'b10;
        wait_busy(1'b0, "rmo_op0_done");
        wait_busy(1'b1, "rmo_op1_start");
        req_valid = 2'b00;
        wait_busy(1'b0, "rmo_op1_done");

        // ALU_LAT=3 instance: capture exactly three edges after the handshake.
        l3_resp_ready = 2'b11;
        l3_req_a[7:0] = 8'd7; l3_req_b[7:0] = 8'd3; l3_req_op[3:0] = 4'h0;
        l3_req_valid = 2'b01;
        #1;
        chk_eq("lat_ready", 32'(l3_req_ready), 32'b01);
        @(posedge clk); #1;
        l3_req_valid = 2'b00;
        chk_eq("lat_busy", 32'(l3_busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk_eq("lat_no_resp", 32'(l3_resp_valid), 32'd0);
            chk_eq("lat_alu_stable", 32'({l3_alu_a, l3_alu_b, l3_alu_op}),
                   32'({8'd7, 8'd3, 4'h0}));
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk_eq("lat_resp_valid", 32'(l3_resp_valid), 32'b01);
        chk_eq("lat_result", 32'(l3_resp_result), 32'd10);
        chk_eq("lat_dz", 32'(l3_resp_dz), 32'd0);
        @(posedge clk); #1;
        chk_eq("lat_idle", 32'(l3_busy), 32'd0);

        @(posedge clk); #1;
        chk_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
